iprefetch_buffer: RTL and testbench

IPREFETCH_BUFFER -- requirements
Module: iprefetch_buffer

---
 rtl/ooo_mem_pkg.sv | 22 ++
 rtl/stride_detector.sv | 96 +++++++++
 rtl/iprefetch_buffer.sv | 131 +++++++++++++
 tb/tb_iprefetch_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_mem_pkg.sv
// Shared types and defaults for the instruction-side memory blocks.
// Tags are line addresses (addr[31:5]); lines are 256 bits wide.
package ooo_mem_pkg;

    localparam int LINE_W         = 256;
    localparam int TAG_W          = 27;
    localparam int OFS_W          = 5;
    localparam int STRIDE_W       = 5;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_MAX_STRIDE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_STEADY  = 2'd3
    } stride_state_e;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/stride_detector.sv
// Miss-stream stride detector; produces the registered
// next-line prefetch address.
module stride_detector
    import ooo_mem_pkg::*;
#(
    parameter int MAX_STRIDE = DEF_MAX_STRIDE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        miss_valid,
    input  tag_t        miss_line,
    output logic [31:0] pf_req_addr
);

    localparam logic signed [TAG_W-1:0] MAX_POS = TAG_W'(MAX_STRIDE);
    localparam logic signed [TAG_W-1:0] MAX_NEG = -MAX_POS;

    stride_state_e               state_q, state_d;
    tag_t                        last_line_q, last_line_d;
    logic signed [STRIDE_W-1:0]  stride_q, stride_d;
    tag_t                        pf_q, pf_d;

    logic signed [TAG_W-1:0]     delta;
    logic signed [TAG_W-1:0]     stride_x;
    logic                        in_range;
    tag_t                        step;

    always_comb begin
        delta       = miss_line - last_line_q;
        stride_x    = {{(TAG_W-STRIDE_W){stride_q[STRIDE_W-1]}}, stride_q};
        in_range    = (delta <= MAX_POS) && (delta >= MAX_NEG);
        state_d     = state_q;
        last_line_d = last_line_q;
        stride_d    = stride_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else if (miss_valid && (delta != '0)) begin
            last_line_d = miss_line;
            unique case (state_q)
                ST_IDLE: state_d = ST_TRAIN;
                ST_TRAIN: begin
                    if (in_range) begin
                        stride_d = delta[STRIDE_W-1:0];
                        state_d  = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (delta == stride_x) begin
                        state_d = ST_STEADY;
                    end else if (in_range) begin
                        stride_d = delta[STRIDE_W-1:0];
                    end else begin
                        state_d = ST_TRAIN;
                    end
                end
                ST_STEADY: begin
                    if (delta != stride_x) begin
                        if (in_range) begin
                            stride_d = delta[STRIDE_W-1:0];
                            state_d  = ST_CONFIRM;
                        end else begin
                            state_d = ST_TRAIN;
                        end
                    end
                end
            endcase
        end

        // Address follows the post-update state so it is valid one edge after the miss.
        if (state_d == ST_STEADY) begin
            step = {{(TAG_W-STRIDE_W){stride_d[STRIDE_W-1]}}, stride_d};
        end else begin
            step = TAG_W'(1);
        end
        pf_d = last_line_d + step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_line_q <= '0;
            stride_q    <= '0;
            pf_q        <= TAG_W'(1);
        end else begin
            state_q     <= state_d;
            last_line_q <= last_line_d;
            stride_q    <= stride_d;
            pf_q        <= pf_d;
        end
    end

    assign pf_req_addr = {pf_q, {OFS_W{1'b0}}};

endmodule

// File: rtl/iprefetch_buffer.sv
// Small fully-associative prefetch line buffer with consume-on-hit
// lookup, same-cycle fill bypass and FIFO replacement.
module iprefetch_buffer
    import ooo_mem_pkg::*;
#(
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int MAX_STRIDE = DEF_MAX_STRIDE,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int OCC_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [31:0]       miss_addr,
    output logic [31:0]       pf_req_addr,
    input  logic              fill_resp,
    input  logic [31:0]       fill_addr,
    input  logic [LINE_W-1:0] fill_data,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    logic [DEPTH-1:0] valid_q, valid_d;
    tag_t             tag_q  [DEPTH];
    line_t            data_q [DEPTH];
    logic [IDX_W-1:0] vptr_q, vptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    tag_t             lk_tag, fl_tag;
    logic [DEPTH-1:0] lk_hit, fl_hit, consume;
    logic             bypass, fill_en, any_free, evict;
    logic [IDX_W-1:0] free_idx, fl_idx, alloc_idx;
    line_t            hit_data;
    logic             unused_ofs;

    assign lk_tag     = lookup_addr[31:OFS_W];
    assign fl_tag     = fill_addr[31:OFS_W];
    assign unused_ofs = ^{miss_addr[OFS_W-1:0], fill_addr[OFS_W-1:0],
                          lookup_addr[OFS_W-1:0]};

    always_comb begin
        lk_hit   = '0;
        fl_hit   = '0;
        hit_data = '0;
        free_idx = '0;
        fl_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            lk_hit[i] = valid_q[i] && (tag_q[i] == lk_tag);
            fl_hit[i] = valid_q[i] && (tag_q[i] == fl_tag);
            if (!valid_q[i]) free_idx = IDX_W'(i);
            if (fl_hit[i])   fl_idx   = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (lk_hit[i]) hit_data = hit_data | data_q[i];
        end

        bypass     = lookup_valid && fill_resp && (fl_tag == lk_tag);
        lookup_hit = lookup_valid && ((|lk_hit) || bypass);
        if (!lookup_valid) begin
            lookup_data = '0;
        end else if (bypass) begin
            lookup_data = fill_data;
        end else begin
            lookup_data = hit_data;
        end

        consume  = lookup_valid ? lk_hit : '0;
        fill_en  = fill_resp && !bypass && !flush;
        any_free = ~&valid_q;
        evict    = fill_en && !(|fl_hit) && !any_free;

        if (|fl_hit) begin
            alloc_idx = fl_idx;
        end else if (any_free) begin
            alloc_idx = free_idx;
        end else begin
            alloc_idx = vptr_q;
        end

        // Fill applied after consume: a victim that is also being read stays valid.
        valid_d = valid_q & ~consume;
        if (fill_en) valid_d[alloc_idx] = 1'b1;
        vptr_d = evict ? vptr_q + IDX_W'(1) : vptr_q;
        if (flush) begin
            valid_d = '0;
            vptr_d  = '0;
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            vptr_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            vptr_q  <= vptr_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[alloc_idx]  <= fl_tag;
            data_q[alloc_idx] <= fill_data;
        end
    end

    assign occupancy = occ_q;

    stride_detector #(
        .MAX_STRIDE (MAX_STRIDE)
    ) u_stride (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .miss_valid  (miss_valid),
        .miss_line   (miss_addr[31:OFS_W]),
        .pf_req_addr (pf_req_addr)
    );

endmodule

// File: tb/tb_iprefetch_buffer.sv
// Directed bench for iprefetch_buffer: stride training, consume-on-hit,
// bypass, FIFO eviction, flush and asynchronous reset.
module tb_iprefetch_buffer;
    import ooo_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic [31:0] pf_req_addr;
    logic        fill_resp;
    logic [31:0] fill_addr;
    line_t       fill_data;
    logic        lookup_valid;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    line_t       lookup_data;
    logic        flush;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    iprefetch_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .pf_req_addr  (pf_req_addr),
        .fill_resp    (fill_resp),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .flush        (flush),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic line_t mk(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(k);
        return {8{w}};
    endfunction

    task automatic check(input string tag, input line_t obs, input line_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        miss_valid   = 1'b0;
        miss_addr    = '0;
        fill_resp    = 1'b0;
        fill_addr    = '0;
        fill_data    = '0;
        lookup_valid = 1'b0;
        lookup_addr  = '0;
        flush        = 1'b0;
    endtask

    task automatic miss(input logic [31:0] a);
        miss_valid = 1'b1;
        miss_addr  = a;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input line_t d);
        fill_resp = 1'b1;
        fill_addr = a;
        fill_data = d;
        tick();
        fill_resp = 1'b0;
    endtask

    task automatic probe(input logic [31:0] a);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        #1;
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] a);
        probe(a);
        check(tag, line_t'(lookup_hit), line_t'(0));
        lookup_valid = 1'b0;
    endtask

    logic [31:0] gone [4];

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check("rst_occ", line_t'(occupancy), line_t'(0));
        check("rst_pf", line_t'(pf_req_addr), line_t'(32'h20));
        check("rst_hit", line_t'(lookup_hit), line_t'(0));
        rst_n = 1'b1;
        tick();
        check("rst_state", line_t'(dut.u_stride.state_q), line_t'(ST_IDLE));
        expect_miss("rst_probe", 32'h0);

        miss(32'h1000);
        check("s1_state", line_t'(dut.u_stride.state_q), line_t'(ST_TRAIN));
        check("s1_pf", line_t'(pf_req_addr), line_t'(32'h1020));
        miss(32'h1040);
        check("s2_state", line_t'(dut.u_stride.state_q), line_t'(ST_CONFIRM));
        check("s2_pf", line_t'(pf_req_addr), line_t'(32'h1060));
        miss(32'h1080);
        check("s3_state", line_t'(dut.u_stride.state_q), line_t'(ST_STEADY));
        check("s3_pf", line_t'(pf_req_addr), line_t'(32'h10C0));
        miss(32'h1084);
        check("same_line_state", line_t'(dut.u_stride.state_q), line_t'(ST_STEADY));
        check("same_line_pf", line_t'(pf_req_addr), line_t'(32'h10C0));

        miss(32'hFFFF_FFA0);
        check("w1_state", line_t'(dut.u_stride.state_q), line_t'(ST_TRAIN));
        check("w1_pf", line_t'(pf_req_addr), line_t'(32'hFFFF_FFC0));
        miss(32'hFFFF_FFC0);
        check("w2_pf", line_t'(pf_req_addr), line_t'(32'hFFFF_FFE0));
        miss(32'hFFFF_FFE0);
        check("w3_state", line_t'(dut.u_stride.state_q), line_t'(ST_STEADY));
        check("w3_pf_wrap", line_t'(pf_req_addr), line_t'(32'h0));

        fill(32'h2000, mk(100));
        check("f1_occ", line_t'(occupancy), line_t'(1));
        probe(32'h2010);
        check("f1_hit", line_t'(lookup_hit), line_t'(1));
        check("f1_data", lookup_data, mk(100));
        tick();
        lookup_valid = 1'b0;
        check("f1_consumed_occ", line_t'(occupancy), line_t'(0));
        probe(32'h2000);
        check("f1_gone_hit", line_t'(lookup_hit), line_t'(0));
        check("f1_gone_data", lookup_data, line_t'(0));
        lookup_valid = 1'b0;

        fill_resp = 1'b1;
        fill_addr = 32'h3000;
        fill_data = mk(200);
        probe(32'h3000);
        check("byp_hit", line_t'(lookup_hit), line_t'(1));
        check("byp_data", lookup_data, mk(200));
        tick();
        fill_resp    = 1'b0;
        lookup_valid = 1'b0;
        check("byp_occ", line_t'(occupancy), line_t'(0));
        expect_miss("byp_not_alloc", 32'h3000);

        for (int k = 0; k < 5; k++) begin
            fill(32'h4000 + 32'(k) * 32'h20, mk(k));
            if (k == 3) check("full_occ", line_t'(occupancy), line_t'(4));
        end
        check("evict_occ", line_t'(occupancy), line_t'(4));
        expect_miss("evicted_first", 32'h4000);
        fill(32'h4040, mk(300));
        check("inplace_occ", line_t'(occupancy), line_t'(4));
        probe(32'h4020);
        check("e1_data", lookup_data, mk(1));
        tick();
        lookup_valid = 1'b0;
        check("e1_occ", line_t'(occupancy), line_t'(3));
        probe(32'h4040);
        check("inplace_data", lookup_data, mk(300));
        tick();
        lookup_valid = 1'b0;
        check("e2_occ", line_t'(occupancy), line_t'(2));

        fill(32'h5000, mk(500));
        fill(32'h5020, mk(520));
        check("refill_occ", line_t'(occupancy), line_t'(4));
        fill_resp = 1'b1;
        fill_addr = 32'h5040;
        fill_data = mk(540);
        probe(32'h4060);
        check("fc_data", lookup_data, mk(3));
        tick();
        fill_resp    = 1'b0;
        lookup_valid = 1'b0;
        check("fc_occ", line_t'(occupancy), line_t'(3));
        expect_miss("fc_victim_gone", 32'h5000);
        fill(32'h50A0, mk(5100));
        check("fc2_occ", line_t'(occupancy), line_t'(4));
        fill_resp = 1'b1;
        fill_addr = 32'h5060;
        fill_data = mk(560);
        probe(32'h5020);
        check("vc_data", lookup_data, mk(520));
        tick();
        fill_resp    = 1'b0;
        lookup_valid = 1'b0;
        check("vc_occ", line_t'(occupancy), line_t'(4));
        probe(32'h5060);
        check("vc_new_data", lookup_data, mk(560));
        tick();
        lookup_valid = 1'b0;
        check("pre_flush_occ", line_t'(occupancy), line_t'(3));

        flush      = 1'b1;
        fill_resp  = 1'b1;
        fill_addr  = 32'h6000;
        fill_data  = mk(600);
        miss_valid = 1'b1;
        miss_addr  = 32'h7000;
        probe(32'h4080);
        check("flush_prehit", line_t'(lookup_hit), line_t'(1));
        check("flush_predata", lookup_data, mk(4));
        tick();
        idle();
        check("flush_occ", line_t'(occupancy), line_t'(0));
        check("flush_state", line_t'(dut.u_stride.state_q), line_t'(ST_IDLE));
        check("flush_pf", line_t'(pf_req_addr), line_t'(32'h0));
        gone[0] = 32'h4080;
        gone[1] = 32'h5040;
        gone[2] = 32'h50A0;
        gone[3] = 32'h6000;
        for (int i = 0; i < 4; i++) expect_miss($sformatf("flush_miss%0d", i), gone[i]);
        miss(32'h7000);
        check("retrain_state", line_t'(dut.u_stride.state_q), line_t'(ST_TRAIN));
        check("retrain_pf", line_t'(pf_req_addr), line_t'(32'h7020));

        fill(32'h8000, mk(800));
        check("pre_rst_occ", line_t'(occupancy), line_t'(1));
        fill_resp = 1'b1;
        fill_addr = 32'h8020;
        fill_data = mk(820);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_occ", line_t'(occupancy), line_t'(0));
        check("arst_state", line_t'(dut.u_stride.state_q), line_t'(ST_IDLE));
        check("arst_pf", line_t'(pf_req_addr), line_t'(32'h20));
        fill_resp = 1'b0;
        rst_n     = 1'b1;
        tick();
        expect_miss("arst_miss0", 32'h8000);
        expect_miss("arst_miss1", 32'h8020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
